// File: rtl/sqrt_square_seq.sv
// Sequential inverse of the integer square root: radical = q*q + r via a radix-2
// shift-add multiplier, one multiplier bit per enabled cycle, with valid/ready on both sides.
module sqrt_square_seq #(
    parameter int Q_WIDTH   = 16,
    parameter int R_WIDTH   = 17,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [Q_WIDTH-1:0]   q_in,
    input  logic [R_WIDTH-1:0]   r_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] radical,
    output logic                 err_range,
    output logic                 overflow
);

    localparam int ACC_W = 2*Q_WIDTH + 2;
    localparam int CNT_W = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Q_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt, mcand;
    logic [Q_WIDTH-1:0] mult;
    logic [CNT_W-1:0]   cnt;
    logic               err_pend;
    logic               accept, busy_last, release_out;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr)
            state <= IDLE;
        else if (ena)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)        state_nxt = BUSY;
            BUSY:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (out_ready)       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state == IDLE) && ena && !aclr;
        accept      = in_ready && in_valid;
        busy_last   = ena && (state == BUSY) && (cnt == CNT_LAST);
        release_out = ena && (state == DONE) && out_ready;
        acc_nxt     = acc + (mult[0] ? (mcand << cnt) : '0);
    end

    // Result registers load from acc_nxt on the final BUSY edge, so DONE entry and
    // out_valid coincide; everything visible is cleared again on hand-off.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            acc       <= '0;
            mcand     <= '0;
            mult      <= '0;
            cnt       <= '0;
            err_pend  <= 1'b0;
            out_valid <= 1'b0;
            radical   <= '0;
            err_range <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                mcand    <= ACC_W'(q_in);
                mult     <= q_in;
                acc      <= ACC_W'(r_in);
                cnt      <= '0;
                err_pend <= ACC_W'(r_in) > (ACC_W'(q_in) << 1);
            end
            if (ena && state == BUSY) begin
                acc  <= acc_nxt;
                mult <= mult >> 1;
                cnt  <= cnt + CNT_W'(1);
            end
            if (busy_last) begin
                out_valid <= 1'b1;
                radical   <= acc_nxt[OUT_WIDTH-1:0];
                overflow  <= |acc_nxt[ACC_W-1:OUT_WIDTH];
                err_range <= err_pend;
            end
            if (release_out) begin
                out_valid <= 1'b0;
                radical   <= '0;
                overflow  <= 1'b0;
                err_range <= 1'b0;
                err_pend  <= 1'b0;
            end
        end
    end

endmodule
